// File: rtl/dflop_pkg.sv
// dflop_pkg: shared FSM state encodings and glitch counter width for the input-conditioning path
package dflop_pkg;
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;
    localparam int GLITCH_W = 8;
endpackage

// File: rtl/dflop_debounce_sync_chain.sv
// sync_chain: SYNC_STAGES-deep flop chain bringing an asynchronous level into the clk domain
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r;
    always_ff @(posedge clk)
        if (!rst_n) r <= {SYNC_STAGES{RESET_LEVEL}};
        else        r <= {r[SYNC_STAGES-2:0], d};
    assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/dflop_debounce.sv
// dflop_debounce: synchronise and debounce a raw level, emitting clean level, edge pulses and busy
// Optional DFLOP_DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt of rejected candidates.
module dflop_debounce import dflop_pkg::*; #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   CNT_W         = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_1,
    output logic out_1,
    output logic rise_1,
    output logic fall_1,
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic busy
);
    logic             s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             out_n, rise_n, fall_n, abort;
    sync_chain #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
        .clk(clk), .rst_n(rst_n), .d(in_1), .q(s)
    );
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        out_n   = out_1;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE_LO, IDLE_HI: begin
                if (s != out_1) begin
                    state_n = out_1 ? WAIT_LO : WAIT_HI;
                    cnt_n   = CNT_W'(1);
                end
            end
            default: begin
                if (s == out_1) begin
                    state_n = out_1 ? IDLE_HI : IDLE_LO;
                    abort   = 1'b1;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    out_n   = s;
                    rise_n  = s;
                    fall_n  = !s;
                    state_n = s ? IDLE_HI : IDLE_LO;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            state  <= RESET_LEVEL ? IDLE_HI : IDLE_LO;
            cnt    <= '0;
            out_1  <= RESET_LEVEL;
            rise_1 <= 1'b0;
            fall_1 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            out_1  <= out_n;
            rise_1 <= rise_n;
            fall_1 <= fall_n;
            busy   <= (state_n == WAIT_HI) || (state_n == WAIT_LO);
        end
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk)
        if (!rst_n)                             glitch_cnt <= '0;
        else if (abort && (glitch_cnt != '1))   glitch_cnt <= glitch_cnt + GLITCH_W'(1);
`endif
endmodule

// File: tb/tb_dflop_debounce.sv
// tb_dflop_debounce: randomized and directed stimulus checked against a run-length debounce model
module tb_dflop_debounce;
    localparam int   SS = 2;
    localparam int   SC = 4;
    localparam logic RL = 1'b0;
    logic clk = 1'b0, rst_n = 1'b0, in_1 = 1'b0;
    logic out_1, rise_1, fall_1, busy;
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif
    int n_vec = 0, n_err = 0;
    logic hist [SS];
    int   run = 0, m_gc = 0;
    logic m_out = RL, m_rise = 1'b0, m_fall = 1'b0;
    dflop_debounce #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RESET_LEVEL(RL), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_1(in_1), .out_1(out_1), .rise_1(rise_1), .fall_1(fall_1),
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .busy(busy)
    );
    always #50 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask
    task automatic tick(input logic rn, input logic d);
        logic s;
        rst_n = rn;
        in_1  = d;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < SS; i++) hist[i] = RL;
            m_out = RL; run = 0; m_rise = 1'b0; m_fall = 1'b0; m_gc = 0;
        end else begin
            s = hist[SS-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_out) begin
                run++;
                if (run == SC) begin
                    m_out = s; m_rise = s; m_fall = !s; run = 0;
                end
            end else begin
                if (run > 0 && m_gc < 255) m_gc++;
                run = 0;
            end
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
        end
        #1;
        check("out_1", 32'(out_1), 32'(m_out));
        check("rise_1", 32'(rise_1), 32'(m_rise));
        check("fall_1", 32'(fall_1), 32'(m_fall));
        check("busy", 32'(busy), 32'(run > 0));
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt", 32'(glitch_cnt), 32'(m_gc));
`endif
    endtask
    initial begin
        int lat;
        logic lvl;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("rst_state", 32'(dut.state), 32'd0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1);
            if (rise_1 && lat == 0) lat = k;
        end
        check("rel_rise_lat", 32'(lat), 32'(SS + SC));
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1);
            if (k >= 3 && k <= 5) check("busy_win", 32'(busy), 32'd1);
            if (rise_1 && lat == 0) lat = k;
        end
        check("clean_rise_lat", 32'(lat), 32'd6);
        check("out_hi", 32'(out_1), 32'd1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0);
            if (fall_1 && lat == 0) lat = k;
        end
        check("clean_fall_lat", 32'(lat), 32'd6);
        for (int k = 0; k < 8; k++) tick(1'b1, k[0] ? 1'b0 : 1'b1);
        check("glitch_out", 32'(out_1), 32'd0);
        for (int k = 1; k <= 3; k++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check("midq_busy", 32'(busy), 32'd0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1);
            if (rise_1 && lat == 0) lat = k;
        end
        check("midq_lat", 32'(lat), 32'd6);
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
`ifdef DFLOP_DEBOUNCE_GLITCH_CNT_EN
        for (int k = 0; k < 300; k++) begin
            tick(1'b1, 1'b1);
            tick(1'b1, 1'b0);
        end
        check("gc_sat", 32'(glitch_cnt), 32'd255);
        check("gc_out", 32'(out_1), 32'd0);
`endif
        lvl = 1'b0;
        for (int p = 0; p < 400; p++) begin
            int len;
            lvl = $urandom_range(0, 3) != 0 ? !lvl : lvl;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) tick($urandom_range(0, 60) != 0, lvl);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
